// File: rtl/fetch_stage.sv
// IF stage: owns the PC, runs the req/valid imem handshake, applies redirects and feeds IF/ID.
// Define FETCH_PERF_CNT_EN to add the fetch_cnt/bubble_cnt performance outputs.
module fetch_stage #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [ADDR_W-1:0] imem_rdata,
    input  logic              imem_valid,
    input  logic              stall_f,
    input  logic              stall_d,
    input  logic              flush_d,
    input  logic              branch_taken_e,
    input  logic [ADDR_W-1:0] branch_target_e,
    input  logic              pcsrc_w,
    input  logic [ADDR_W-1:0] result_w,
    output logic [ADDR_W-1:0] instr_d,
    output logic [ADDR_W-1:0] pc_plus8_d,
    output logic              valid_d
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]       fetch_cnt,
    output logic [31:0]       bubble_cnt
`endif
);

    localparam logic [ADDR_W-1:0] ALIGN = ~ADDR_W'(3);
    localparam logic [ADDR_W-1:0] FOUR  = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] EIGHT = ADDR_W'(8);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        HOLD,
        DRAIN
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] pc_f;
    logic [ADDR_W-1:0] hold_q;
    logic [ADDR_W-1:0] target;
    logic [ADDR_W-1:0] deliv_data;
    logic              redirect;
    logic              stall;
    logic              deliver;

    assign redirect  = branch_taken_e | pcsrc_w;
    assign stall     = stall_f | stall_d;
    assign target    = (branch_taken_e ? branch_target_e : result_w) & ALIGN;
    assign imem_addr = pc_f & ALIGN;

    // A redirect on the same edge always discards whatever data is in flight.
    always_comb begin
        deliver    = 1'b0;
        deliv_data = imem_rdata;
        unique case (1'b1)
            (state == REQ): begin
                deliver = imem_valid && !stall && !redirect;
            end
            (state == HOLD): begin
                deliver    = !stall && !redirect;
                deliv_data = hold_q;
            end
            default: begin
                deliver = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            pc_f     <= RESET_PC;
            imem_req <= 1'b0;
            hold_q   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (redirect) pc_f <= target;
                    state    <= REQ;
                    imem_req <= 1'b1;
                end
                REQ: begin
                    if (redirect) begin
                        pc_f     <= target;
                        state    <= imem_valid ? REQ : DRAIN;
                        imem_req <= imem_valid;
                    end else if (imem_valid && stall) begin
                        hold_q   <= imem_rdata;
                        state    <= HOLD;
                        imem_req <= 1'b0;
                    end else if (imem_valid) begin
                        pc_f <= pc_f + FOUR;
                    end
                end
                HOLD: begin
                    if (redirect) begin
                        pc_f     <= target;
                        state    <= REQ;
                        imem_req <= 1'b1;
                    end else if (!stall) begin
                        pc_f     <= pc_f + FOUR;
                        state    <= REQ;
                        imem_req <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (redirect) pc_f <= target;
                    // The response arriving here belongs to the abandoned fetch.
                    if (imem_valid) begin
                        state    <= REQ;
                        imem_req <= 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instr_d    <= '0;
            pc_plus8_d <= '0;
            valid_d    <= 1'b0;
        end else if (flush_d) begin
            instr_d    <= '0;
            pc_plus8_d <= '0;
            valid_d    <= 1'b0;
        end else if (!stall_d) begin
            if (deliver) begin
                instr_d    <= deliv_data;
                pc_plus8_d <= imem_addr + EIGHT;
                valid_d    <= 1'b1;
            end else begin
                instr_d <= '0;
                valid_d <= 1'b0;
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_cnt  <= '0;
            bubble_cnt <= '0;
        end else if (!flush_d && !stall_d) begin
            if (deliver) fetch_cnt <= fetch_cnt + 32'd1;
            else         bubble_cnt <= bubble_cnt + 32'd1;
        end
    end
`endif

endmodule
